// File: rtl/uart_tx_en.sv
// Enable-gated UART transmitter: 1 start bit, 8 data bits LSB first, StopBits stop bits.
// Bit timing comes from the oversample tick on en; each bit spans Oversample en pulses.
module uart_tx_en #(
    parameter int Oversample = 16,
    parameter int StopBits   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       out,
    output logic       busy,
    output logic       done
);
    localparam int SW = (Oversample > 2) ? $clog2(Oversample) : 1;
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(Oversample - 1);
    localparam logic [0:0]    STOP_LAST   = 1'(StopBits - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [SW-1:0] sample_cnt;
    logic [0:0]    stop_cnt;
    logic          tick;

    assign tick = en && (sample_cnt == '0);

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            IDLE:  if (valid) state_nx = START;
            START: if (tick) state_nx = DATA;
            DATA:  if (tick && bit_cnt == 3'd7) state_nx = STOP;
            STOP: begin
                if (tick && stop_cnt == STOP_LAST) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            sample_cnt <= SAMPLE_LAST;
            stop_cnt   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (valid) begin
                    shreg      <= data;
                    bit_cnt    <= 3'd0;
                    sample_cnt <= SAMPLE_LAST;
                end
            end else if (en) begin
                if (sample_cnt == '0) begin
                    // every bit boundary restarts the oversample count
                    sample_cnt <= SAMPLE_LAST;
                    case (state)
                        START: bit_cnt <= 3'd0;
                        DATA: begin
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) stop_cnt <= 1'b0;
                        end
                        STOP: if (stop_cnt != STOP_LAST) stop_cnt <= stop_cnt + 1'b1;
                        default: ;
                    endcase
                end else begin
                    sample_cnt <= sample_cnt - SW'(1);
                end
            end
        end
    end

    // line level decodes flops only, so it never follows the inputs combinationally
    assign out   = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);
endmodule

// File: doc/uart_tx_en.md
Name: uart_tx_en

Overview:
- Enable-gated UART transmitter; the transmit-side counterpart of the oversampled UART receiver in the same UART block.
- Serialises one 8-bit byte per valid/ready handshake: 1 start bit (0), 8 data bits LSB first, StopBits stop bits (1).
- Bit timing comes from an external oversample tick on en; each bit lasts exactly Oversample en pulses.
- Sits between the host-side byte source and the serial pin, sharing the baud-tick generator with the receiver.

Parameters:
- Oversample, 16, en pulses per serial bit; must be >= 2.
- StopBits, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  oversample tick; all bit-timing counters advance only when en=1.
- data  input  8  byte to transmit; sampled on handshake.
- valid  input  1  source has a byte on data.
- ready  output  1  transmitter can accept a byte this cycle.
- out  output  1  serial line; idle high.
- busy  output  1  a frame is in progress (state != IDLE).
- done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset (sync, active-high, overrides everything incl. mid-frame):
  - state=IDLE, out=1, ready=1, busy=0, done=0.
  - shift register=0, bitCount=0, sampleCount=Oversample-1.
  - A partially sent frame is abandoned; the line returns high the cycle after reset.
- State machine: IDLE, START, DATA, STOP.
- sampleCount:
  - Width $clog2(Oversample).
  - Loaded with Oversample-1 on every state or bit transition.
  - Decrements on each en=1 cycle; en=0 holds all state.
  - Define tick = en && sampleCount==0, i.e. the end of the current bit.
- IDLE:
  - ready=1, out=1.
  - valid&&ready at a rising edge latches data into the shift register and moves to START. This is independent of en.
  - Handshake is accepted regardless of en phase.
- START:
  - out=0.
  - On tick: go to DATA with bitCount=0.
- DATA:
  - out = shift register bit 0.
  - On tick: shift right by 1 and increment bitCount.
  - On the tick where bitCount==7: go to STOP with stopCount=0.
- STOP:
  - out=1.
  - On tick: if stopCount==StopBits-1, go to IDLE; else increment stopCount and reload sampleCount.
- done:
  - Combinational: done = (state==STOP) && tick && (stopCount==StopBits-1).
  - Exactly one cycle per frame.
- ready = (state==IDLE), registered via state.
  - No acceptance during STOP; a back-to-back byte is accepted on the first IDLE cycle.
  - Minimum inter-frame gap is one clk cycle, not one bit.
- valid while busy: ignored. data changes after acceptance do not affect the frame in flight.
- out is driven from state/shift-register flops only; it is glitch-free and combinationally independent of inputs.
- Latency:
  - out falls on the first cycle after acceptance.
  - Each bit spans exactly Oversample en pulses, measured from its first cycle.
  - Frame length = (1+8+StopBits)*Oversample en pulses.
- Simultaneous events:
  - reset with valid: reset wins; byte not accepted.
  - en=0 on the tick cycle delays the transition until the next en=1 cycle with sampleCount==0.

Test Plan:
- Reset, en=1 constantly, Oversample=16, StopBits=1, send 0xA5 accepted at cycle 0 -> out=0 cycles 1-16; then bits 1,0,1,0,0,1,0,1 each for 16 cycles (cycles 17-144); out=1 cycles 145-160; done=1 only at cycle 160; ready=1 from cycle 161.
- en pulsed every 4th clk, send 0x00 -> each bit lasts 64 clks; out low for 9*64 clks after acceptance, then high for 64; exactly one done pulse.
- Two bytes 0x55, 0xFF with valid held high -> second accepted on cycle 161; continuous 0x55 waveform followed by a start bit then eight 1s; two done pulses 161 cycles apart.
- Assert reset for one cycle mid-DATA (cycle 70) -> out=1, busy=0, ready=1 on the next cycle; no done pulse; next byte transmits cleanly.
- StopBits=2, send 0x80 -> stop high for 32 cycles; done at cycle 176.
- valid pulsed and data toggled during an active frame -> ignored; transmitted bits match the originally accepted byte.
